// File: rtl/cdc_arb_pkg.sv
// rtl/cdc_arb_pkg.sv - shared types and helpers for the CDC FIFO source arbiter
package cdc_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_prio_sel.sv
// rtl/rr_prio_sel.sv - combinational rotating first-one finder
// Scans req_i starting at start_i and wrapping; start_i must be below N.
module rr_prio_sel
  import cdc_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  int cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(start_i) + k;
      if (cand >= N) cand = cand - N;
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/cdc_fifo_src_arbiter.sv
// rtl/cdc_fifo_src_arbiter.sv - packet-aware round-robin arbiter feeding a CDC FIFO source port
// Optional per-requester packet counters on grant_cnt_o when CDC_ARB_GRANT_CNT_EN is defined.
module cdc_fifo_src_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ-1:0]               req_mask_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ-1:0]               req_last_i,
  input  logic [NUM_REQ*WIDTH-1:0]         req_data_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  output logic                             out_valid_o,
  output logic [WIDTH-1:0]                 out_data_o,
  output logic [id_width(NUM_REQ)-1:0]     out_id_o,
  output logic                             out_last_o,
  input  logic                             out_ready_i
`ifdef CDC_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]     grant_cnt_o
`endif
);

  localparam int IW = id_width(NUM_REQ);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  logic          arb_found;
  logic [IW-1:0] arb_idx;
  logic [IW-1:0] sel;
  logic          xfer;

  rr_prio_sel #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_prio_sel (
    .req_i   (req_valid_i & req_mask_i),
    .start_i (rr_ptr_q),
    .found_o (arb_found),
    .idx_o   (arb_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      if (out_last_o) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);
      end else if (state_q == ARB_IDLE) begin
        state_d = ARB_LOCK;
        owner_d = sel;
      end
    end
  end

  // While locked the mask is ignored so a packet always runs to its last beat.
  always_comb begin
    sel         = (state_q == ARB_LOCK) ? owner_q : arb_idx;
    out_valid_o = (state_q == ARB_LOCK) ? req_valid_i[owner_q] : arb_found;
    out_id_o    = sel;
    out_data_o  = '0;
    out_last_o  = 1'b0;
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IW'(i)) begin
        out_data_o = req_data_i[i*WIDTH +: WIDTH];
        out_last_o = req_last_i[i];
      end
    end
    if ((state_q == ARB_LOCK) || arb_found) begin
      req_ready_o[sel] = out_ready_i;
    end
    xfer = out_valid_o & out_ready_i;
  end

`ifdef CDC_ARB_GRANT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];

  // Counters saturate rather than wrap so a stuck-high value is recognisable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer && out_last_o && (sel == IW'(i)) && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign grant_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// tb/tb_cdc_fifo_src_arbiter.sv - directed vector bench for cdc_fifo_src_arbiter
module tb_cdc_fifo_src_arbiter;

`ifdef CDC_ARB_GRANT_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   mask, valid, last, ready;
  logic [127:0] data;
  logic         ovalid, olast, ordy;
  logic [31:0]  odata;
  logic [1:0]   oid;
`ifdef CDC_ARB_GRANT_CNT_EN
  logic [4*CW-1:0] gcnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cdc_fifo_src_arbiter #(
    .NUM_REQ   (4),
    .WIDTH     (32),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_mask_i  (mask),
    .req_valid_i (valid),
    .req_last_i  (last),
    .req_data_i  (data),
    .req_ready_o (ready),
    .out_valid_o (ovalid),
    .out_data_o  (odata),
    .out_id_o    (oid),
    .out_last_o  (olast),
    .out_ready_i (ordy)
`ifdef CDC_ARB_GRANT_CNT_EN
    ,
    .grant_cnt_o (gcnt)
`endif
  );

  typedef struct {
    bit       rst;
    bit [3:0] mask;
    bit [3:0] valid;
    bit [3:0] last;
    bit       ordy;
    bit       e_valid;
    int       e_id;
    bit       e_last;
    bit [3:0] e_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit r, input bit [3:0] m, input bit [3:0] v, input bit [3:0] l,
                              input bit o, input bit ev, input int eid, input bit el, input bit [3:0] er);
    vec_t t;
    t.rst = r; t.mask = m; t.valid = v; t.last = l; t.ordy = o;
    t.e_valid = ev; t.e_id = eid; t.e_last = el; t.e_ready = er;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mask = '0; valid = '0; last = '0; ordy = 1'b0;
    data = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};

    // reset state
    vecs.push_back(mk(1, 4'hF, 4'h0, 4'h0, 1, 0, 0, 0, 4'b0000));
    // single-beat round robin
    vecs.push_back(mk(0, 4'hF, 4'hF, 4'hF, 1, 1, 0, 1, 4'b0001));
    vecs.push_back(mk(0, 4'hF, 4'hF, 4'hF, 1, 1, 1, 1, 4'b0010));
    vecs.push_back(mk(0, 4'hF, 4'hF, 4'hF, 1, 1, 2, 1, 4'b0100));
    vecs.push_back(mk(0, 4'hF, 4'hF, 4'hF, 1, 1, 3, 1, 4'b1000));
    vecs.push_back(mk(0, 4'hF, 4'hF, 4'hF, 1, 1, 0, 1, 4'b0001));
    // req1 3-beat packet while req0/2 valid
    vecs.push_back(mk(0, 4'hF, 4'b0111, 4'b0101, 1, 1, 1, 0, 4'b0010));
    vecs.push_back(mk(0, 4'hF, 4'b0111, 4'b0101, 1, 1, 1, 0, 4'b0010));
    vecs.push_back(mk(0, 4'hF, 4'b0111, 4'b0111, 1, 1, 1, 1, 4'b0010));
    vecs.push_back(mk(0, 4'hF, 4'b0101, 4'b0101, 1, 1, 2, 1, 4'b0100));
    vecs.push_back(mk(0, 4'hF, 4'b0001, 4'b0001, 1, 1, 0, 1, 4'b0001));
    // backpressure mid-packet for 5 cycles
    vecs.push_back(mk(0, 4'hF, 4'b0010, 4'b0000, 1, 1, 1, 0, 4'b0010));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 4'hF, 4'b0111, 4'b0000, 0, 1, 1, 0, 4'b0000));
    vecs.push_back(mk(0, 4'hF, 4'b0111, 4'b0010, 1, 1, 1, 1, 4'b0010));
    // mask 1011: requester 2 skipped
    vecs.push_back(mk(0, 4'b1011, 4'hF, 4'hF, 1, 1, 3, 1, 4'b1000));
    vecs.push_back(mk(0, 4'b1011, 4'hF, 4'hF, 1, 1, 0, 1, 4'b0001));
    vecs.push_back(mk(0, 4'b1011, 4'hF, 4'hF, 1, 1, 1, 1, 4'b0010));
    vecs.push_back(mk(0, 4'b1011, 4'hF, 4'hF, 1, 1, 3, 1, 4'b1000));
    // clearing mask bit 1 during a req1 packet
    vecs.push_back(mk(0, 4'b1011, 4'b0010, 4'b0000, 1, 1, 1, 0, 4'b0010));
    vecs.push_back(mk(0, 4'b1001, 4'hF, 4'b0000, 1, 1, 1, 0, 4'b0010));
    vecs.push_back(mk(0, 4'b1001, 4'hF, 4'b0010, 1, 1, 1, 1, 4'b0010));
    vecs.push_back(mk(0, 4'b1001, 4'hF, 4'hF, 1, 1, 3, 1, 4'b1000));
    // owner drops valid mid-packet
    vecs.push_back(mk(0, 4'hF, 4'b0100, 4'b0000, 1, 1, 2, 0, 4'b0100));
    vecs.push_back(mk(0, 4'hF, 4'b1011, 4'hF, 1, 0, 0, 0, 4'b0100));
    vecs.push_back(mk(0, 4'hF, 4'b0100, 4'b0100, 1, 1, 2, 1, 4'b0100));
    vecs.push_back(mk(0, 4'hF, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000));
    // reset on beat 2 of a 4-beat req3 packet
    vecs.push_back(mk(0, 4'hF, 4'b1000, 4'b0000, 1, 1, 3, 0, 4'b1000));
    vecs.push_back(mk(1, 4'hF, 4'hF, 4'b0000, 1, 1, 3, 0, 4'b1000));
    vecs.push_back(mk(0, 4'hF, 4'hF, 4'hF, 1, 1, 0, 1, 4'b0001));

    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; mask = vecs[i].mask; valid = vecs[i].valid;
      last = vecs[i].last; ordy = vecs[i].ordy;
      #3;
      chk($sformatf("v%0d valid", i), 32'(ovalid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d ready", i), 32'(ready), 32'(vecs[i].e_ready));
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d id", i), 32'(oid), 32'(vecs[i].e_id));
        chk($sformatf("v%0d last", i), 32'(olast), 32'(vecs[i].e_last));
        chk($sformatf("v%0d data", i), odata, 32'hD000_0000 + 32'(vecs[i].e_id));
      end
      next_cycle();
    end

    // long round-robin run after a clean reset
    rst = 1'b1; mask = 4'hF; valid = '0; last = 4'hF; ordy = 1'b1;
    next_cycle();
    rst = 1'b0; valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #3;
      chk($sformatf("rr%0d id", k), 32'(oid), 32'(k % 4));
      chk($sformatf("rr%0d valid", k), 32'(ovalid), 32'd1);
      next_cycle();
    end

`ifdef CDC_ARB_GRANT_CNT_EN
    rst = 1'b1; valid = '0;
    next_cycle();
    rst = 1'b0;
    #3;
    chk("cnt reset", 32'(gcnt), 32'd0);
    next_cycle();
    valid = 4'b1000; last = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      if (k == 1) chk("cnt3 after 2", 32'(gcnt[3*CW +: CW]), 32'd2);
    end
    valid = '0;
    #3;
    chk("cnt3 saturated", 32'(gcnt[3*CW +: CW]), 32'd3);
    chk("cnt others", 32'(gcnt[3*CW-1:0]), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
